// File: rtl/lv_pwm_int_proc_mc.sv
// rtl/lv_pwm_int_proc_mc.sv - multi-channel LV PWM dead-time / mismatch fault detector and interrupt aggregator
//
// Purpose:
//   Per PWM channel, flags a dead-time fault on a selectable edge of the
//   dead-time violation level, and a compare/gate mismatch fault once the two
//   waves have disagreed for i_mm_thr consecutive cycles. Faults set sticky,
//   clearable, maskable flags. These are ORed into one interrupt. The first
//   unmasked fault (channel and type) is also captured.
//
// Ports:
//   i_clk               block clock
//   i_rst               asynchronous active-high reset
//   i_lv_pwm_dt         per-channel dead-time violation level
//   i_lv_pwm_cmp_wave   per-channel expected PWM wave
//   i_lv_pwm_gate_wave  per-channel observed gate wave
//   i_dt_mode           dead-time edge select: 00 rise, 01 fall, 10 both, 11 off
//   i_mm_thr            mismatch run length in cycles, 0 = mismatch detect off
//   i_int_msk           per-channel mask for o_int and first-fault capture
//   i_int_clr           per-channel clear pulse for the sticky flags
//   i_ff_clr            clear pulse for the first-fault record
//   o_lv_pwm_dterr      raw per-channel dead-time fault pulse
//   o_lv_pwm_mmerr      raw per-channel mismatch fault level
//   o_dt_sticky         sticky dead-time flags
//   o_mm_sticky         sticky mismatch flags
//   o_int               aggregate interrupt
//   o_ff_vld            first-fault record valid
//   o_ff_ch             channel index of the first fault
//   o_ff_type           first-fault type: 0 mismatch, 1 dead-time

module lv_pwm_int_proc_mc #(
  parameter int CH_NUM   = 3,
  parameter int CNT_W    = 8,
  parameter int SYNC_STG = 0,
  parameter int CH_ID_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [CH_NUM-1:0]  i_lv_pwm_dt,
  input  logic [CH_NUM-1:0]  i_lv_pwm_cmp_wave,
  input  logic [CH_NUM-1:0]  i_lv_pwm_gate_wave,
  input  logic [1:0]         i_dt_mode,
  input  logic [CNT_W-1:0]   i_mm_thr,
  input  logic [CH_NUM-1:0]  i_int_msk,
  input  logic [CH_NUM-1:0]  i_int_clr,
  input  logic               i_ff_clr,
  output logic [CH_NUM-1:0]  o_lv_pwm_dterr,
  output logic [CH_NUM-1:0]  o_lv_pwm_mmerr,
  output logic [CH_NUM-1:0]  o_dt_sticky,
  output logic [CH_NUM-1:0]  o_mm_sticky,
  output logic               o_int,
  output logic               o_ff_vld,
  output logic [CH_ID_W-1:0] o_ff_ch,
  output logic               o_ff_type
);

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0] dt_s;
  logic [CH_NUM-1:0] cmp_s;
  logic [CH_NUM-1:0] gate_s;

  generate
    if (SYNC_STG == 0) begin : g_nosync
      assign dt_s   = i_lv_pwm_dt;
      assign cmp_s  = i_lv_pwm_cmp_wave;
      assign gate_s = i_lv_pwm_gate_wave;
    end else begin : g_sync
      logic [SYNC_STG-1:0][CH_NUM-1:0] dt_q;
      logic [SYNC_STG-1:0][CH_NUM-1:0] cmp_q;
      logic [SYNC_STG-1:0][CH_NUM-1:0] gate_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          dt_q   <= '0;
          cmp_q  <= '0;
          gate_q <= '0;
        end else begin
          dt_q[0]   <= i_lv_pwm_dt;
          cmp_q[0]  <= i_lv_pwm_cmp_wave;
          gate_q[0] <= i_lv_pwm_gate_wave;
          for (int s = 1; s < SYNC_STG; s++) begin
            dt_q[s]   <= dt_q[s-1];
            cmp_q[s]  <= cmp_q[s-1];
            gate_q[s] <= gate_q[s-1];
          end
        end
      end

      assign dt_s   = dt_q[SYNC_STG-1];
      assign cmp_s  = cmp_q[SYNC_STG-1];
      assign gate_s = gate_q[SYNC_STG-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Dead-time edge detection
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0] dt_ff;
  logic [CH_NUM-1:0] dt_rise;
  logic [CH_NUM-1:0] dt_fall;
  logic [CH_NUM-1:0] dterr_raw;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dt_ff <= '0;
    end else begin
      dt_ff <= dt_s;
    end
  end

  assign dt_rise = dt_s & ~dt_ff;
  assign dt_fall = ~dt_s & dt_ff;

  always_comb begin
    dterr_raw = '0;
    case (i_dt_mode)
      2'b00:   dterr_raw = dt_rise;
      2'b01:   dterr_raw = dt_fall;
      2'b10:   dterr_raw = dt_rise | dt_fall;
      default: dterr_raw = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Compare/gate mismatch run counters
  // ---------------------------------------------------------------------------
  // The counter holds (consecutive mismatch cycles - 1), clamped at thr-1, so
  // the compare fires on the thr-th mismatch cycle with no extra latency.
  // Clamping to the live threshold lets a lowered threshold take effect at
  // once and a raised one continue counting from where it stood.
  logic [CH_NUM-1:0] mm_x;
  logic [CH_NUM-1:0] mmerr_raw;
  logic [CNT_W-1:0]  thr_m1;
  logic              thr_on;
  logic [CNT_W-1:0]  mm_cnt [CH_NUM];

  assign mm_x   = cmp_s ^ gate_s;
  assign thr_on = |i_mm_thr;
  assign thr_m1 = i_mm_thr - CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        mm_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (!thr_on || !mm_x[c]) begin
          mm_cnt[c] <= '0;
        end else if (mm_cnt[c] >= thr_m1) begin
          mm_cnt[c] <= thr_m1;
        end else begin
          mm_cnt[c] <= mm_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    mmerr_raw = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      mmerr_raw[c] = mm_x[c] & thr_on & (mm_cnt[c] >= thr_m1);
    end
  end

  // Raw outputs are combinational; force them low during reset so a level
  // already present on the inputs cannot leak through while flops are cleared.
  assign o_lv_pwm_dterr = i_rst ? '0 : dterr_raw;
  assign o_lv_pwm_mmerr = i_rst ? '0 : mmerr_raw;

  // ---------------------------------------------------------------------------
  // Sticky flags and aggregate interrupt
  // ---------------------------------------------------------------------------
  // A new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dt_sticky <= '0;
      o_mm_sticky <= '0;
    end else begin
      o_dt_sticky <= dterr_raw | (o_dt_sticky & ~i_int_clr);
      o_mm_sticky <= mmerr_raw | (o_mm_sticky & ~i_int_clr);
    end
  end

  assign o_int = |((o_mm_sticky | o_dt_sticky) & ~i_int_msk);

  // ---------------------------------------------------------------------------
  // First-fault capture
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0]  cand_mm;
  logic [CH_NUM-1:0]  cand_any;
  logic [CH_ID_W-1:0] sel_ch;
  logic               sel_type;

  assign cand_mm  = mmerr_raw & ~i_int_msk;
  assign cand_any = (mmerr_raw | dterr_raw) & ~i_int_msk;

  // Scan from the top down so the lowest-index candidate is the last writer.
  always_comb begin
    sel_ch   = '0;
    sel_type = 1'b0;
    for (int c = CH_NUM - 1; c >= 0; c--) begin
      if (cand_any[c]) begin
        sel_ch   = CH_ID_W'(c);
        sel_type = ~cand_mm[c];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ff_vld  <= 1'b0;
      o_ff_ch   <= '0;
      o_ff_type <= 1'b0;
    end else if ((!o_ff_vld || i_ff_clr) && (|cand_any)) begin
      o_ff_vld  <= 1'b1;
      o_ff_ch   <= sel_ch;
      o_ff_type <= sel_type;
    end else if (i_ff_clr) begin
      o_ff_vld  <= 1'b0;
      o_ff_ch   <= '0;
      o_ff_type <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lv_pwm_int_proc_mc.sv
// tb/tb_lv_pwm_int_proc_mc.sv - self-checking bench for lv_pwm_int_proc_mc
module tb_lv_pwm_int_proc_mc;

  localparam int CH_NUM   = 3;
  localparam int CNT_W    = 8;
  localparam int SYNC_STG = 0;
  localparam int CH_ID_W  = 2;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [CH_NUM-1:0]   i_lv_pwm_dt;
  logic [CH_NUM-1:0]   i_lv_pwm_cmp_wave;
  logic [CH_NUM-1:0]   i_lv_pwm_gate_wave;
  logic [1:0]          i_dt_mode;
  logic [CNT_W-1:0]    i_mm_thr;
  logic [CH_NUM-1:0]   i_int_msk;
  logic [CH_NUM-1:0]   i_int_clr;
  logic                i_ff_clr;
  logic [CH_NUM-1:0]   o_lv_pwm_dterr;
  logic [CH_NUM-1:0]   o_lv_pwm_mmerr;
  logic [CH_NUM-1:0]   o_dt_sticky;
  logic [CH_NUM-1:0]   o_mm_sticky;
  logic                o_int;
  logic                o_ff_vld;
  logic [CH_ID_W-1:0]  o_ff_ch;
  logic                o_ff_type;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  lv_pwm_int_proc_mc #(
    .CH_NUM   (CH_NUM),
    .CNT_W    (CNT_W),
    .SYNC_STG (SYNC_STG),
    .CH_ID_W  (CH_ID_W)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_lv_pwm_dt        (i_lv_pwm_dt),
    .i_lv_pwm_cmp_wave  (i_lv_pwm_cmp_wave),
    .i_lv_pwm_gate_wave (i_lv_pwm_gate_wave),
    .i_dt_mode          (i_dt_mode),
    .i_mm_thr           (i_mm_thr),
    .i_int_msk          (i_int_msk),
    .i_int_clr          (i_int_clr),
    .i_ff_clr           (i_ff_clr),
    .o_lv_pwm_dterr     (o_lv_pwm_dterr),
    .o_lv_pwm_mmerr     (o_lv_pwm_mmerr),
    .o_dt_sticky        (o_dt_sticky),
    .o_mm_sticky        (o_mm_sticky),
    .o_int              (o_int),
    .o_ff_vld           (o_ff_vld),
    .o_ff_ch            (o_ff_ch),
    .o_ff_type          (o_ff_type)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic zero_inputs();
    i_lv_pwm_dt        = '0;
    i_lv_pwm_cmp_wave  = '0;
    i_lv_pwm_gate_wave = '0;
    i_dt_mode          = 2'b00;
    i_mm_thr           = '0;
    i_int_msk          = '0;
    i_int_clr          = '0;
    i_ff_clr           = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    zero_inputs();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Table vectors: mismatch-path rows, dt held low, gate held low, no mask.
  typedef struct {
    logic [2:0] cmp;
    logic [7:0] thr;
    logic [2:0] clr;
    logic       ffclr;
    logic [2:0] e_mm;
    logic [2:0] e_mms;
    logic       e_int;
    logic       e_vld;
    logic [1:0] e_ch;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [2:0] cmp, input logic [7:0] thr,
                             input logic [2:0] clr, input logic ffclr,
                             input logic [2:0] e_mm, input logic [2:0] e_mms,
                             input logic e_int, input logic e_vld, input logic [1:0] e_ch);
    vec_t r;
    r.cmp = cmp; r.thr = thr; r.clr = clr; r.ffclr = ffclr;
    r.e_mm = e_mm; r.e_mms = e_mms; r.e_int = e_int; r.e_vld = e_vld; r.e_ch = e_ch;
    return r;
  endfunction

  // Reference model state: consecutive mismatch run per channel, previous dt
  // level, sticky flags and the first-fault record.
  int         m_run[CH_NUM];
  logic [2:0] m_dp, m_ms, m_ds;
  logic       m_fv, m_ft;
  logic [1:0] m_fch;

  task automatic model_clear();
    for (int c = 0; c < CH_NUM; c++) m_run[c] = 0;
    m_dp = '0; m_ms = '0; m_ds = '0;
    m_fv = 1'b0; m_ft = 1'b0; m_fch = '0;
  endtask

  task automatic run_random();
    logic [2:0] err, e_mm, e_dt, cand;
    logic       e_int, x, rise, fall, found;
    int         thr;
    err = '0;
    do_reset();
    model_clear();
    for (int seg = 0; seg < 6; seg++) begin
      thr = $urandom_range(0, 6);
      i_dt_mode = 2'($urandom_range(0, 3));
      for (int k = 0; k < 50; k++) begin
        for (int c = 0; c < CH_NUM; c++) begin
          if ($urandom_range(0, 3) == 0) err[c] = ~err[c];
          if ($urandom_range(0, 7) == 0) i_lv_pwm_cmp_wave[c] = ~i_lv_pwm_cmp_wave[c];
          if ($urandom_range(0, 3) == 0) i_lv_pwm_dt[c] = ~i_lv_pwm_dt[c];
        end
        // Threshold changes only at a matched cycle so the run restarts.
        i_lv_pwm_gate_wave = (k == 0) ? i_lv_pwm_cmp_wave : (i_lv_pwm_cmp_wave ^ err);
        i_mm_thr  = 8'(thr);
        if (k % 16 == 0) i_int_msk = 3'($urandom_range(0, 7));
        i_int_clr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        i_ff_clr  = ($urandom_range(0, 9) == 0);
        @(negedge i_clk);
        e_int = 1'b0;
        for (int c = 0; c < CH_NUM; c++) begin
          x = i_lv_pwm_cmp_wave[c] ^ i_lv_pwm_gate_wave[c];
          e_mm[c] = x && (thr != 0) && (m_run[c] + 1 >= thr);
          rise = i_lv_pwm_dt[c] && !m_dp[c];
          fall = !i_lv_pwm_dt[c] && m_dp[c];
          case (i_dt_mode)
            2'b00:   e_dt[c] = rise;
            2'b01:   e_dt[c] = fall;
            2'b10:   e_dt[c] = rise || fall;
            default: e_dt[c] = 1'b0;
          endcase
          if ((m_ms[c] || m_ds[c]) && !i_int_msk[c]) e_int = 1'b1;
        end
        chk("rnd_mmerr",  32'(o_lv_pwm_mmerr), 32'(e_mm));
        chk("rnd_dterr",  32'(o_lv_pwm_dterr), 32'(e_dt));
        chk("rnd_mms",    32'(o_mm_sticky),    32'(m_ms));
        chk("rnd_dts",    32'(o_dt_sticky),    32'(m_ds));
        chk("rnd_int",    32'(o_int),          32'(e_int));
        chk("rnd_ff",     32'({o_ff_vld, o_ff_ch, o_ff_type}), 32'({m_fv, m_fch, m_ft}));
        for (int c = 0; c < CH_NUM; c++) begin
          x = i_lv_pwm_cmp_wave[c] ^ i_lv_pwm_gate_wave[c];
          m_run[c] = (x && thr != 0) ? m_run[c] + 1 : 0;
        end
        m_ms = e_mm | (m_ms & ~i_int_clr);
        m_ds = e_dt | (m_ds & ~i_int_clr);
        m_dp = i_lv_pwm_dt;
        cand = (e_mm | e_dt) & ~i_int_msk;
        if ((!m_fv || i_ff_clr) && cand != 0) begin
          found = 1'b0;
          for (int c = 0; c < CH_NUM; c++) begin
            if (cand[c] && !found) begin
              found = 1'b1;
              m_fch = 2'(c);
              m_ft  = !e_mm[c];
            end
          end
          m_fv = 1'b1;
        end else if (i_ff_clr) begin
          m_fv = 1'b0; m_fch = '0; m_ft = 1'b0;
        end
        next_cycle();
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    zero_inputs();
    #2;
    chk("reset_outputs", 32'({o_lv_pwm_dterr, o_lv_pwm_mmerr, o_dt_sticky, o_mm_sticky,
                              o_int, o_ff_vld, o_ff_ch, o_ff_type}), 32'd0);

    // ---------------- table-driven mismatch/clear sequence ----------------
    tbl.push_back(v(3'b010, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b010, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b010, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b010, 4, 3'b000, 0, 3'b010, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b010, 4, 3'b000, 0, 3'b010, 3'b010, 1, 1, 1));
    tbl.push_back(v(3'b010, 4, 3'b000, 0, 3'b010, 3'b010, 1, 1, 1));
    tbl.push_back(v(3'b000, 4, 3'b000, 0, 3'b000, 3'b010, 1, 1, 1));
    tbl.push_back(v(3'b000, 4, 3'b010, 0, 3'b000, 3'b010, 1, 1, 1));
    tbl.push_back(v(3'b000, 4, 3'b000, 0, 3'b000, 3'b000, 0, 1, 1));
    tbl.push_back(v(3'b000, 4, 3'b000, 1, 3'b000, 3'b000, 0, 1, 1));
    tbl.push_back(v(3'b000, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(3'b001, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b000, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(3'b001, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b000, 4, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b100, 1, 3'b000, 0, 3'b100, 3'b000, 0, 0, 0));
    tbl.push_back(v(3'b000, 1, 3'b000, 0, 3'b000, 3'b100, 1, 1, 2));
    tbl.push_back(v(3'b100, 0, 3'b000, 0, 3'b000, 3'b100, 1, 1, 2));

    do_reset();
    foreach (tbl[i]) begin
      i_lv_pwm_cmp_wave = tbl[i].cmp;
      i_mm_thr          = tbl[i].thr;
      i_int_clr         = tbl[i].clr;
      i_ff_clr          = tbl[i].ffclr;
      @(negedge i_clk);
      chk($sformatf("tbl%0d_mmerr", i), 32'(o_lv_pwm_mmerr), 32'(tbl[i].e_mm));
      chk($sformatf("tbl%0d_mms", i),   32'(o_mm_sticky),    32'(tbl[i].e_mms));
      chk($sformatf("tbl%0d_int", i),   32'(o_int),          32'(tbl[i].e_int));
      chk($sformatf("tbl%0d_ff", i),    32'({o_ff_vld, o_ff_ch, o_ff_type}),
                                        32'({tbl[i].e_vld, tbl[i].e_ch, 1'b0}));
      chk($sformatf("tbl%0d_dt", i),    32'({o_lv_pwm_dterr, o_dt_sticky}), 32'd0);
      next_cycle();
    end

    // ---------------- dead-time both edges, then disabled ----------------
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      i_dt_mode = (pass == 0) ? 2'b10 : 2'b11;
      for (int k = 1; k <= 7; k++) begin
        i_lv_pwm_dt = (k <= 5) ? 3'b100 : 3'b000;
        @(negedge i_clk);
        chk($sformatf("dt_mode%0d_k%0d_dterr", pass, k), 32'(o_lv_pwm_dterr),
            (pass == 0 && (k == 1 || k == 6)) ? 32'h4 : 32'h0);
        if (k == 2)
          chk($sformatf("dt_mode%0d_sticky", pass),
              32'({o_dt_sticky, o_int, o_ff_vld, o_ff_ch, o_ff_type}),
              (pass == 0) ? 32'({3'b100, 1'b1, 1'b1, 2'd2, 1'b1}) : 32'd0);
        next_cycle();
      end
    end

    // ---------------- coincident dterr[0] and mmerr[2], mask ----------------
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      i_mm_thr          = 8'd1;
      i_int_msk         = (pass == 0) ? 3'b000 : 3'b001;
      i_lv_pwm_dt       = 3'b001;
      i_lv_pwm_cmp_wave = 3'b100;
      @(negedge i_clk);
      chk($sformatf("coin%0d_raw", pass), 32'({o_lv_pwm_dterr, o_lv_pwm_mmerr}),
          32'({3'b001, 3'b100}));
      next_cycle();
      i_lv_pwm_dt       = 3'b000;
      i_lv_pwm_cmp_wave = 3'b000;
      @(negedge i_clk);
      chk($sformatf("coin%0d_ff", pass), 32'({o_ff_vld, o_ff_ch, o_ff_type}),
          (pass == 0) ? 32'({1'b1, 2'd0, 1'b1}) : 32'({1'b1, 2'd2, 1'b0}));
      chk($sformatf("coin%0d_sticky", pass), 32'({o_dt_sticky, o_mm_sticky, o_int}),
          32'({3'b001, 3'b100, 1'b1}));
      if (pass == 1) begin
        i_int_msk = 3'b101;
        #1;
        chk("coin_mask_drops_int", 32'(o_int), 32'd0);
        chk("coin_mask_keeps_sticky", 32'(o_mm_sticky), 32'h4);
      end
      next_cycle();
    end

    // ---------------- clear while mismatch persists ----------------
    do_reset();
    i_mm_thr          = 8'd2;
    i_lv_pwm_cmp_wave = 3'b010;
    next_cycle();
    next_cycle();
    i_int_clr = 3'b010;
    @(negedge i_clk);
    chk("clr_busy_mmerr", 32'({o_lv_pwm_mmerr, o_mm_sticky}), 32'({3'b010, 3'b010}));
    next_cycle();
    i_int_clr         = 3'b000;
    i_lv_pwm_cmp_wave = 3'b000;
    @(negedge i_clk);
    chk("clr_set_wins", 32'(o_mm_sticky), 32'h2);
    next_cycle();
    i_int_clr = 3'b010;
    next_cycle();
    i_int_clr = 3'b000;
    @(negedge i_clk);
    chk("clr_idle", 32'({o_mm_sticky, o_int}), 32'd0);
    next_cycle();

    // ---------------- asynchronous reset mid-mismatch ----------------
    do_reset();
    i_dt_mode   = 2'b00;
    i_lv_pwm_dt = 3'b010;
    next_cycle();
    i_mm_thr          = 8'd4;
    i_lv_pwm_cmp_wave = 3'b001;
    next_cycle();
    next_cycle();
    @(negedge i_clk);
    chk("arst_pre_state", 32'({o_dt_sticky, o_int, o_ff_vld}), 32'({3'b010, 1'b1, 1'b1}));
    #1;
    i_rst = 1'b1;
    #1;
    chk("arst_all_zero", 32'({o_lv_pwm_dterr, o_lv_pwm_mmerr, o_dt_sticky, o_mm_sticky,
                             o_int, o_ff_vld, o_ff_ch, o_ff_type}), 32'd0);
    i_lv_pwm_dt = 3'b000;
    next_cycle();
    i_rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clk);
      chk($sformatf("arst_restart_k%0d", k), 32'(o_lv_pwm_mmerr), (k == 4) ? 32'h1 : 32'h0);
      next_cycle();
    end

    // ---------------- randomized against reference model ----------------
    run_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
